// File: rtl/alu_mul_seq_pkg.sv
// Shared ALU opcodes and multiplier state encoding.
package alu_mul_seq_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLTU = 4'b0111;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_TEST  = 3'd1,
    ST_ADD   = 3'd2,
    ST_CARRY = 3'd3,
    ST_DONE  = 3'd4
  } mul_state_e;

endpackage

// File: rtl/alu_mul_seq_if.sv
// Core <-> multiplier handshake: start pulse with operands, busy/done with hi/lo product.
interface alu_mul_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] opr_a;
  logic [WIDTH-1:0] opr_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, opr_a, opr_b, input busy, done, hi, lo);
  modport slave  (input start, opr_a, opr_b, output busy, done, hi, lo);
endinterface

// File: rtl/alu_mul_seq_alu.sv
// The execute-stage integer ALU, reused by the multiplier for its adds and unsigned compares.
module alu_mul_seq_alu
  import alu_mul_seq_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [W-1:0] opr1,
  input  logic [W-1:0] opr2,
  input  logic [3:0]   aluop,
  output logic [W-1:0] result
);

  always_comb begin
    result = '0;
    case (aluop)
      ALU_AND:  result = opr1 & opr2;
      ALU_OR:   result = opr1 | opr2;
      ALU_ADD:  result = opr1 + opr2;
      ALU_SUB:  result = opr1 - opr2;
      ALU_SLTU: result = {{(W-1){1'b0}}, (opr1 < opr2)};
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/alu_mul_seq.sv
// Sequential unsigned WIDTHxWIDTH multiplier: shift-and-add using the shared ALU for every add and carry.
//   state | meaning
//   IDLE  | waiting for start, operands latched on accept
//   TEST  | inspect multiplier LSB; shift right if zero
//   ADD   | sum <= acc_hi + mcand
//   CARRY | carry <= (sum < mcand); shift {carry,sum,acc_lo} right
//   DONE  | one-cycle done pulse, hi/lo valid
module alu_mul_seq
  import alu_mul_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic         clk,
  input  logic         rst,
  alu_mul_seq_if.slave bus
);

  mul_state_e       state;
  logic [WIDTH-1:0] mcand, acc_hi, acc_lo, sum;
  logic [CNT_W-1:0] cnt;
  logic             busy_q, done_q;
  logic [WIDTH-1:0] hi_q, lo_q;

  logic [WIDTH-1:0] alu_opr1, alu_opr2, alu_result;
  logic [3:0]       alu_op;
  logic [WIDTH-1:0] nxt_hi, nxt_lo;
  logic             carry, shift_step, last_step;

  alu_mul_seq_alu #(.W(WIDTH)) u_alu (
    .opr1   (alu_opr1),
    .opr2   (alu_opr2),
    .aluop  (alu_op),
    .result (alu_result)
  );

  always_comb begin
    alu_opr1 = '0;
    alu_opr2 = '0;
    alu_op   = ALU_AND;
    case (state)
      ST_ADD: begin
        alu_opr1 = acc_hi;
        alu_opr2 = mcand;
        alu_op   = ALU_ADD;
      end
      ST_CARRY: begin
        alu_opr1 = sum;
        alu_opr2 = mcand;
        alu_op   = ALU_SLTU;
      end
      default: ;
    endcase
  end

  // The add wrapped exactly when the truncated sum is below mcand.
  always_comb begin
    carry  = 1'b0;
    nxt_hi = acc_hi;
    nxt_lo = acc_lo;
    case (state)
      ST_TEST: begin
        nxt_hi = {1'b0, acc_hi[WIDTH-1:1]};
        nxt_lo = {acc_hi[0], acc_lo[WIDTH-1:1]};
      end
      ST_CARRY: begin
        carry  = alu_result[0];
        nxt_hi = {carry, sum[WIDTH-1:1]};
        nxt_lo = {sum[0], acc_lo[WIDTH-1:1]};
      end
      default: ;
    endcase
  end

  assign shift_step = ((state == ST_TEST) && !acc_lo[0]) || (state == ST_CARRY);
  assign last_step  = (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      mcand  <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      sum    <= '0;
      cnt    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            mcand  <= bus.opr_a;
            acc_lo <= bus.opr_b;
            acc_hi <= '0;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= ST_TEST;
          end
        end
        ST_TEST:  if (acc_lo[0]) state <= ST_ADD;
        ST_ADD: begin
          sum   <= alu_result;
          state <= ST_CARRY;
        end
        ST_CARRY: ;
        ST_DONE:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase

      if (shift_step) begin
        acc_hi <= nxt_hi;
        acc_lo <= nxt_lo;
        cnt    <= cnt + CNT_W'(1);
        if (last_step) begin
          state  <= ST_DONE;
          busy_q <= 1'b0;
          done_q <= 1'b1;
          hi_q   <= nxt_hi;
          lo_q   <= nxt_lo;
        end else begin
          state  <= ST_TEST;
        end
      end
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Scoreboard bench for alu_mul_seq: expected product and done latency queued at start, checked at done.
module tb_alu_mul_seq;

  typedef struct {
    logic [63:0] prod;
    int          lat;
  } exp_t;

  localparam int MAXC = 150;

  logic clk = 1'b0;
  logic rst = 1'b1;
  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  logic [63:0] prev_prod = 64'd0;

  int          obs_lat;
  logic        obs_busy1, obs_changed, obs_done_after;
  logic [31:0] obs_hi, obs_lo, obs_h0, obs_l0;

  alu_mul_seq_if #(.WIDTH(32)) bus_if ();

  alu_mul_seq #(.WIDTH(32), .CNT_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  task automatic launch(input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    @(negedge clk);
    bus_if.opr_a = a;
    bus_if.opr_b = b;
    bus_if.start = 1'b1;
    e.prod = 64'(a) * 64'(b);
    e.lat  = 33 + 2 * $countones(b);
    sb.push_back(e);
    @(posedge clk);
    #1;
    bus_if.start = 1'b0;
    bus_if.opr_a = $urandom;
    bus_if.opr_b = $urandom;
  endtask

  // Observes one operation after its accept edge; intrude>0 pulses a stray start in that cycle.
  task automatic wait_done(input int intrude);
    obs_lat = -1;
    obs_changed = 1'b0;
    obs_done_after = 1'b1;
    obs_busy1 = 1'b0;
    obs_h0 = bus_if.hi;
    obs_l0 = bus_if.lo;
    obs_hi = '0;
    obs_lo = '0;
    for (int k = 1; k <= MAXC; k++) begin
      @(negedge clk);
      if (k == 1) obs_busy1 = bus_if.busy;
      if (intrude > 0 && k == intrude) begin
        bus_if.start = 1'b1;
        bus_if.opr_a = 32'd9;
        bus_if.opr_b = 32'd9;
      end
      if (intrude > 0 && k == intrude + 1) bus_if.start = 1'b0;
      if (bus_if.done) begin
        obs_lat = k;
        obs_hi  = bus_if.hi;
        obs_lo  = bus_if.lo;
        break;
      end
      if (bus_if.hi !== obs_h0 || bus_if.lo !== obs_l0) obs_changed = 1'b1;
    end
    bus_if.start = 1'b0;
    if (obs_lat > 0) begin
      @(negedge clk);
      obs_done_after = bus_if.done;
    end
  endtask

  task automatic test_reset();
    bus_if.start = 1'b0;
    bus_if.opr_a = 32'hDEAD_BEEF;
    bus_if.opr_b = 32'hCAFE_F00D;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++;
    if (bus_if.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", bus_if.busy); end
    tests++;
    if (bus_if.done !== 1'b0) begin fails++; $display("FAIL reset_done got=%b exp=0", bus_if.done); end
    tests++;
    if ({bus_if.hi, bus_if.lo} !== 64'd0) begin
      fails++; $display("FAIL reset_hilo got=%h_%h exp=0", bus_if.hi, bus_if.lo);
    end
    rst = 1'b0;
    prev_prod = 64'd0;
  endtask

  task automatic test_basic();
    exp_t e;
    launch(32'd3, 32'd5);
    wait_done(0);
    e = sb.pop_front();
    tests++;
    if (obs_busy1 !== 1'b1) begin fails++; $display("FAIL basic_busy_c1 got=%b exp=1", obs_busy1); end
    tests++;
    if (obs_lat != e.lat) begin fails++; $display("FAIL basic_latency got=%0d exp=%0d", obs_lat, e.lat); end
    tests++;
    if ({obs_hi, obs_lo} !== e.prod) begin
      fails++; $display("FAIL basic_product got=%h_%h exp=%h", obs_hi, obs_lo, e.prod);
    end
    tests++;
    if (obs_done_after !== 1'b0) begin fails++; $display("FAIL basic_done_pulse got=%b exp=0", obs_done_after); end
    tests++;
    if (obs_changed || {obs_h0, obs_l0} !== prev_prod) begin
      fails++; $display("FAIL basic_hold changed=%b got=%h_%h exp=%h", obs_changed, obs_h0, obs_l0, prev_prod);
    end
    prev_prod = e.prod;
  endtask

  task automatic test_corner(input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    launch(a, b);
    wait_done(0);
    e = sb.pop_front();
    tests++;
    if (obs_lat != e.lat) begin
      fails++; $display("FAIL corner_latency a=%h b=%h got=%0d exp=%0d", a, b, obs_lat, e.lat);
    end
    tests++;
    if ({obs_hi, obs_lo} !== e.prod) begin
      fails++; $display("FAIL corner_product a=%h b=%h got=%h_%h exp=%h", a, b, obs_hi, obs_lo, e.prod);
    end
    tests++;
    if (obs_changed || {obs_h0, obs_l0} !== prev_prod) begin
      fails++; $display("FAIL corner_hold changed=%b got=%h_%h exp=%h", obs_changed, obs_h0, obs_l0, prev_prod);
    end
    prev_prod = e.prod;
  endtask

  task automatic test_start_while_busy();
    exp_t e;
    launch(32'd3, 32'd7);
    wait_done(10);
    e = sb.pop_front();
    tests++;
    if (obs_lat != 39 || e.lat != 39) begin
      fails++; $display("FAIL busy_start_latency got=%0d exp=39", obs_lat);
    end
    tests++;
    if ({obs_hi, obs_lo} !== 64'd21) begin
      fails++; $display("FAIL busy_start_product got=%h_%h exp=21", obs_hi, obs_lo);
    end
    tests++;
    if (obs_changed || {obs_h0, obs_l0} !== prev_prod) begin
      fails++; $display("FAIL busy_start_hold changed=%b got=%h_%h exp=%h", obs_changed, obs_h0, obs_l0, prev_prod);
    end
    prev_prod = e.prod;
    // A stray start must not have queued a second operation.
    repeat (40) @(negedge clk);
    tests++;
    if (bus_if.busy !== 1'b0 || {bus_if.hi, bus_if.lo} !== 64'd21) begin
      fails++; $display("FAIL busy_start_no_queue busy=%b got=%h_%h exp=0/21", bus_if.busy, bus_if.hi, bus_if.lo);
    end
  endtask

  task automatic test_reset_abort();
    exp_t e;
    logic seen_done;
    launch(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    for (int k = 1; k <= 20; k++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    void'(sb.pop_front());
    tests++;
    if (bus_if.busy !== 1'b0 || bus_if.done !== 1'b0 || {bus_if.hi, bus_if.lo} !== 64'd0) begin
      fails++; $display("FAIL abort_outputs busy=%b done=%b hilo=%h_%h exp=0", bus_if.busy, bus_if.done, bus_if.hi, bus_if.lo);
    end
    rst = 1'b0;
    prev_prod = 64'd0;
    seen_done = 1'b0;
    repeat (110) begin
      @(negedge clk);
      if (bus_if.done === 1'b1 || bus_if.busy === 1'b1) seen_done = 1'b1;
    end
    tests++;
    if (seen_done !== 1'b0) begin fails++; $display("FAIL abort_no_done got=%b exp=0", seen_done); end
    launch(32'd3, 32'd5);
    wait_done(0);
    e = sb.pop_front();
    tests++;
    if (obs_lat != e.lat || {obs_hi, obs_lo} !== 64'd15) begin
      fails++; $display("FAIL abort_restart lat=%0d exp=%0d got=%h_%h exp=15", obs_lat, e.lat, obs_hi, obs_lo);
    end
    prev_prod = e.prod;
  endtask

  task automatic test_random();
    exp_t e;
    logic [31:0] a, b;
    for (int i = 0; i < 5; i++) begin
      a = $urandom;
      b = $urandom;
      launch(a, b);
      wait_done(0);
      e = sb.pop_front();
      tests++;
      if (obs_lat != e.lat || {obs_hi, obs_lo} !== e.prod) begin
        fails++;
        $display("FAIL random a=%h b=%h lat=%0d exp=%0d got=%h_%h exp=%h", a, b, obs_lat, e.lat, obs_hi, obs_lo, e.prod);
      end
      prev_prod = e.prod;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corner(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    test_corner(32'h1234_5678, 32'h0000_0000);
    test_corner(32'h8000_0000, 32'h0000_0002);
    test_start_while_busy();
    test_reset_abort();
    test_random();
    tests++;
    if (sb.size() != 0) begin fails++; $display("FAIL scoreboard_left got=%0d exp=0", sb.size()); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_mul_seq.md
Name: alu_mul_seq

Overview:
- Multi-cycle unsigned 32x32->64 multiply controller (MIPS multu semantics).
- Computes the product by shift-and-add, sequencing one instance of the existing 32-bit ALU for every addition and carry detection. No dedicated adder.
- Sits beside the execute stage. The core pulses start, waits for done, then reads hi/lo.

Parameters:
- WIDTH, 32, operand width. Must equal the ALU width (32); any other value is unsupported.
- CNT_W, 5, iteration counter width (log2 WIDTH).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- opr_a  input  32  multiplicand; latched when start is accepted
- opr_b  input  32  multiplier; latched when start is accepted
- busy  output  1  high in TEST/ADD/CARRY
- done  output  1  one-cycle pulse when hi/lo become valid
- hi  output  32  product bits [63:32], registered
- lo  output  32  product bits [31:0], registered

Behaviour:
- Reset (synchronous, active-high): state=IDLE; busy=0; done=0; hi=0; lo=0; working registers and counter cleared.
- Reset mid-operation aborts the operation. The next cycle shows IDLE with all outputs zero and no done pulse.
- Working registers: mcand (32), acc_hi (32), acc_lo (32), sum (32), cnt (CNT_W).
- IDLE:
  - busy=0.
  - If start=1: mcand<=opr_a; acc_lo<=opr_b; acc_hi<=0; cnt<=0; go to TEST.
  - If start=0: stay in IDLE.
- TEST (ALU operands don't-care):
  - If acc_lo[0]=1: go to ADD.
  - Else: {acc_hi,acc_lo}<={1'b0,acc_hi,acc_lo}>>1 and cnt<=cnt+1. If cnt==31 go to DONE, else TEST.
- ADD: ALU opr1=acc_hi, opr2=mcand, ALUop=ADD (4'b0010); sum<=result; go to CARRY.
- CARRY:
  - ALU opr1=sum, opr2=mcand, ALUop=SLTU (4'b0111); carry=result[0]. This is valid because sum wrapped iff sum<mcand (unsigned compare).
  - {acc_hi,acc_lo}<={carry,sum,acc_lo}>>1 and cnt<=cnt+1.
  - If cnt==31 go to DONE, else TEST.
- Product register load: hi<=acc_hi and lo<=acc_lo on the edge entering DONE.
- DONE: done=1, busy=0, go to IDLE. start is ignored in this cycle.
- ALU drive outside ADD/CARRY: opr1=opr2=0, ALUop=4'b0000. The zero flag is unused.
- Latency, with start sampled at edge 0: done is high in cycle 1+32+2*popcount(opr_b). Range is 33 (opr_b=0) to 97 (opr_b=all ones).
- Outputs hi/lo hold their value until the next DONE and do not change while busy.
- start while busy or in DONE is ignored entirely: no queuing, and latched operands are unaffected.
- Operand inputs may change freely after acceptance.
- Overflow is impossible: the 64-bit result is exact, and the internal carry is at most 1 bit per step.

Decomposition:
- Shared package/header holds:
  - ALU opcode constants: ALU_ADD=4'b0010, ALU_SUB=4'b0110, ALU_AND=4'b0000, ALU_OR=4'b0001, ALU_SLTU=4'b0111.
  - State encoding (IDLE, TEST, ADD, CARRY, DONE; 3-bit).
- One sub-module: the existing ALU, instantiated once, with its operand/opcode inputs driven combinationally by the FSM.
- All remaining logic (FSM, counter, shift registers, output regs) lives in alu_mul_seq.

Test Plan:
- opr_a=3, opr_b=5, single start pulse -> busy high from cycle 1; done=1 exactly in cycle 37; hi=0x00000000, lo=0x0000000F; done low in cycle 38.
- opr_a=0xFFFFFFFF, opr_b=0xFFFFFFFF -> done in cycle 97; hi=0xFFFFFFFE, lo=0x00000001. This exercises carry=1 on every step.
- opr_a=0x12345678, opr_b=0 -> done in cycle 33; hi=0, lo=0. The ADD state is never entered.
- opr_a=0x80000000, opr_b=2 -> done in cycle 35; hi=0x00000001, lo=0x00000000.
- Start 3x7. In cycle 10, assert start with opr_a=9, opr_b=9 -> ignored; done in cycle 1+32+6=39 with lo=21. hi/lo stay at the previous product until then.
- Start 0xFFFFFFFF x 0xFFFFFFFF, assert rst in cycle 20 -> cycle 21: busy=0, done=0, hi=0, lo=0, no done pulse afterward. A fresh 3x5 start then completes with lo=15.
